maxmin_stream_feeder: RTL and testbench

MAXMIN_STREAM_FEEDER -- requirements
Module: maxmin_stream_feeder

---
 rtl/maxmin_stream_feeder.sv | 136 +++++++++++++
 tb/tb_maxmin_stream_feeder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maxmin_stream_feeder.sv
// Streams a block of 32-bit words from memory through an external max/min
// accelerator, one word at a time, and reports the final running max/min.
module maxmin_stream_feeder #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_base_i,
  input  logic [15:0]       cmd_len_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              acc_clear_o,
  output logic              acc_start_o,
  output logic [31:0]       acc_data_o,
  input  logic              acc_done_i,
  input  logic [31:0]       acc_data_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [7:0]        res_max_o,
  output logic [7:0]        res_min_o,
  output logic [15:0]       res_count_o,
  output logic              res_err_o,
  output logic              busy_o
);
  // Watchdog only needs to reach TIMEOUT-1: expiry fires in the TIMEOUT-th wait cycle.
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_WAIT_RD, S_START, S_WAIT_DONE, S_RESULT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       len_q, len_d, cnt_q, cnt_d;
  logic [31:0]       data_q, data_d;
  logic [7:0]        max_q, max_d, min_q, min_d;
  logic              err_q, err_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              wd_expire;
  logic              unused_acc_hi;

  assign unused_acc_hi = ^acc_data_i[31:16];
  assign wd_expire     = (wd_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      max_q   <= 8'h00;
      min_q   <= 8'hFF;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      max_q   <= max_d;
      min_q   <= min_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    max_d   = max_q;
    min_d   = min_q;
    err_d   = err_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: if (cmd_valid_i) begin
        addr_d  = cmd_base_i;
        len_d   = cmd_len_i;
        cnt_d   = '0;
        max_d   = 8'h00;
        min_d   = 8'hFF;
        err_d   = 1'b0;
        state_d = (cmd_len_i == 16'd0) ? S_RESULT : S_CLEAR;
      end
      S_CLEAR:   state_d = S_FETCH;
      S_FETCH:   state_d = S_WAIT_RD;
      S_WAIT_RD: begin
        data_d  = mem_rdata_i;
        state_d = S_START;
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT_DONE;
      end
      // done takes priority over a same-cycle watchdog expiry
      S_WAIT_DONE: if (acc_done_i) begin
        max_d   = acc_data_i[15:8];
        min_d   = acc_data_i[7:0];
        cnt_d   = cnt_q + 16'd1;
        addr_d  = addr_q + 1'b1;
        state_d = ((cnt_q + 16'd1) == len_q) ? S_RESULT : S_FETCH;
      end else if (wd_expire) begin
        err_d   = 1'b1;
        state_d = S_RESULT;
      end else begin
        wd_d    = wd_q + 1'b1;
      end
      S_RESULT:  if (res_ready_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = (state_q == S_IDLE) && !arst_i;
    busy_o      = (state_q != S_IDLE);
    acc_clear_o = (state_q == S_CLEAR);
    mem_req_o   = (state_q == S_FETCH);
    acc_start_o = (state_q == S_START);
    res_valid_o = (state_q == S_RESULT);
    mem_addr_o  = addr_q;
    acc_data_o  = data_q;
    res_max_o   = max_q;
    res_min_o   = min_q;
    res_count_o = cnt_q;
    res_err_o   = err_q;
  end

endmodule

// File: tb/tb_maxmin_stream_feeder.sv
// Directed bench for maxmin_stream_feeder with a byte-wise max/min accelerator
// model and a one-cycle-latency memory model.
module tb_maxmin_stream_feeder;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [15:0] cmd_base = '0, cmd_len = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        acc_clear, acc_start;
  logic [31:0] acc_data_o;
  logic        acc_done = 1'b0;
  logic [31:0] acc_data_i;
  logic        res_valid, res_ready = 1'b0;
  logic [7:0]  res_max, res_min;
  logic [15:0] res_count;
  logic        res_err, busy;

  int ncmp = 0, nerr = 0;

  maxmin_stream_feeder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .arst_i(arst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_base_i(cmd_base), .cmd_len_i(cmd_len),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
    .acc_clear_o(acc_clear), .acc_start_o(acc_start), .acc_data_o(acc_data_o),
    .acc_done_i(acc_done), .acc_data_i(acc_data_i),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_max_o(res_max), .res_min_o(res_min), .res_count_o(res_count),
    .res_err_o(res_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // memory: read data one cycle after the request
  logic [31:0] mem [0:65535];
  logic [15:0] rd_log[$];
  int req_cnt = 0, clr_cnt = 0, res_cnt = 0;
  always @(posedge clk) begin
    if (mem_req) begin
      mem_rdata <= mem[mem_addr];
      rd_log.push_back(mem_addr);
      req_cnt++;
    end
    if (acc_clear) clr_cnt++;
    if (res_valid && res_ready) res_cnt++;
  end

  // accelerator: running byte max/min, done after dly_cfg extra wait cycles
  logic [7:0] m_max = 8'h00, m_min = 8'hFF;
  logic       pend = 1'b0, done_en = 1'b1;
  int         dly_cfg = 0, dly_cnt = 0;
  assign acc_data_i = {16'h0, m_max, m_min};
  always @(posedge clk) begin
    if (arst || acc_clear) begin
      m_max <= 8'h00; m_min <= 8'hFF; pend <= 1'b0; acc_done <= 1'b0;
    end else begin
      acc_done <= 1'b0;
      if (acc_start) begin
        logic [7:0] mx, mn;
        mx = m_max; mn = m_min;
        for (int b = 0; b < 4; b++) begin
          if (acc_data_o[b*8 +: 8] > mx) mx = acc_data_o[b*8 +: 8];
          if (acc_data_o[b*8 +: 8] < mn) mn = acc_data_o[b*8 +: 8];
        end
        m_max <= mx; m_min <= mn;
        if (done_en && dly_cfg == 0) acc_done <= 1'b1;
        else begin pend <= 1'b1; dly_cnt <= dly_cfg - 1; end
      end else if (pend && done_en) begin
        if (dly_cnt == 0) begin acc_done <= 1'b1; pend <= 1'b0; end
        else dly_cnt <= dly_cnt - 1;
      end
    end
  end

  task automatic tick; @(posedge clk); #1; endtask

  task automatic send_cmd(input logic [15:0] base, input logic [15:0] len);
    int n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    if (!cmd_ready) begin $display("FAIL cmd_ready_wait: never ready"); nerr++; end
    ncmp++;
    cmd_valid = 1'b1; cmd_base = base; cmd_len = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!res_valid && n < 400) begin tick(); n++; end
    if (!res_valid) begin $display("FAIL res_valid_wait: timed out after %0d cycles", n); nerr++; end
    ncmp++;
  endtask

  task automatic accept_result;
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  task automatic test_reset;
    arst = 1'b1; tick(); tick();
    if (cmd_ready !== 1'b0) begin $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); nerr++; end ncmp++;
    if ({busy, mem_req, acc_clear, acc_start, res_valid, res_err} !== 6'b0) begin
      $display("FAIL rst_bits: got %b want 000000", {busy, mem_req, acc_clear, acc_start, res_valid, res_err}); nerr++; end ncmp++;
    if ({res_max, res_min, res_count} !== {8'h00, 8'hFF, 16'h0}) begin
      $display("FAIL rst_res: got %h/%h/%h want 00/ff/0000", res_max, res_min, res_count); nerr++; end ncmp++;
    if ({acc_data_o, mem_addr} !== 48'h0) begin
      $display("FAIL rst_data_addr: got %h %h want 0 0", acc_data_o, mem_addr); nerr++; end ncmp++;
    arst = 1'b0; #1;
    if (cmd_ready !== 1'b1) begin $display("FAIL rst_release_ready: got %b want 1", cmd_ready); nerr++; end ncmp++;
  endtask

  task automatic test_basic;
    int r0, c0, s0, n;
    mem[16'h10] = 32'h01020304; mem[16'h11] = 32'h05060708; mem[16'h12] = 32'h090A0B0C;
    dly_cfg = 1; r0 = rd_log.size(); c0 = clr_cnt; s0 = res_cnt;
    send_cmd(16'h0010, 16'd3);
    wait_result(n);
    if (rd_log.size() - r0 !== 3) begin $display("FAIL basic_nreads: got %0d want 3", rd_log.size() - r0); nerr++; end ncmp++;
    for (int i = 0; i < 3 && r0 + i < rd_log.size(); i++) begin
      if (rd_log[r0+i] !== 16'h10 + 16'(i)) begin
        $display("FAIL basic_addr%0d: got %h want %h", i, rd_log[r0+i], 16'h10 + 16'(i)); nerr++; end
      ncmp++;
    end
    if ({res_max, res_min, res_count, res_err} !== {8'h0C, 8'h01, 16'd3, 1'b0}) begin
      $display("FAIL basic_result: got %h/%h/%0d/%b want 0c/01/3/0", res_max, res_min, res_count, res_err); nerr++; end ncmp++;
    if (clr_cnt - c0 !== 1) begin $display("FAIL basic_clear: got %0d pulses want 1", clr_cnt - c0); nerr++; end ncmp++;
    accept_result();
    if ({res_valid, cmd_ready} !== 2'b01) begin
      $display("FAIL basic_post: got valid/ready %b want 01", {res_valid, cmd_ready}); nerr++; end ncmp++;
    if (res_cnt - s0 !== 1) begin $display("FAIL basic_nres: got %0d want 1", res_cnt - s0); nerr++; end ncmp++;
  endtask

  task automatic test_len0;
    int q0 = req_cnt;
    while (!cmd_ready) tick();
    cmd_valid = 1'b1; cmd_base = 16'h0100; cmd_len = 16'd0; #1;
    if (res_valid !== 1'b0) begin $display("FAIL len0_early: got %b want 0", res_valid); nerr++; end ncmp++;
    tick(); cmd_valid = 1'b0;
    // second cycle counting the handshake cycle
    if (res_valid !== 1'b1) begin $display("FAIL len0_valid: got %b want 1", res_valid); nerr++; end ncmp++;
    if ({res_max, res_min, res_count, res_err} !== {8'h00, 8'hFF, 16'd0, 1'b0}) begin
      $display("FAIL len0_result: got %h/%h/%0d/%b want 00/ff/0/0", res_max, res_min, res_count, res_err); nerr++; end ncmp++;
    accept_result(); tick();
    if (req_cnt - q0 !== 0) begin $display("FAIL len0_memreq: got %0d reqs want 0", req_cnt - q0); nerr++; end ncmp++;
  endtask

  task automatic test_wrap;
    int r0, n;
    mem[16'hFFFF] = 32'h11223344; mem[16'h0000] = 32'h55667788;
    dly_cfg = 0; r0 = rd_log.size();
    send_cmd(16'hFFFF, 16'd2);
    wait_result(n);
    // 1 CLEAR + 2 words at the 4-cycle minimum
    if (n !== 9) begin $display("FAIL wrap_latency: got %0d cycles want 9", n); nerr++; end ncmp++;
    if (rd_log.size() - r0 !== 2 || rd_log[r0] !== 16'hFFFF || rd_log[r0+1] !== 16'h0000) begin
      $display("FAIL wrap_addrs: got %0d reads first %h", rd_log.size() - r0, rd_log[r0]); nerr++; end ncmp++;
    if ({res_max, res_min, res_count, res_err} !== {8'h88, 8'h11, 16'd2, 1'b0}) begin
      $display("FAIL wrap_result: got %h/%h/%0d/%b want 88/11/2/0", res_max, res_min, res_count, res_err); nerr++; end ncmp++;
    accept_result();
  endtask

  task automatic test_timeout;
    int n = 0;
    mem[16'h20] = 32'hA0B0C0D0; done_en = 1'b0; dly_cfg = 0;
    send_cmd(16'h0020, 16'd2);
    while (!acc_start && n < 50) begin tick(); n++; end
    if (acc_start !== 1'b1) begin $display("FAIL to_start: no acc_start"); nerr++; end ncmp++;
    n = 0;
    do begin
      tick(); n++;
      if (n == TIMEOUT && acc_data_o !== 32'hA0B0C0D0) begin
        $display("FAIL to_data_hold: got %h want a0b0c0d0", acc_data_o); nerr++; end
    end while (!res_valid && n < 100);
    ncmp++;
    if (n !== TIMEOUT + 1) begin $display("FAIL to_cycles: got %0d want %0d", n, TIMEOUT + 1); nerr++; end ncmp++;
    if ({res_max, res_min, res_count, res_err} !== {8'h00, 8'hFF, 16'd0, 1'b1}) begin
      $display("FAIL to_result: got %h/%h/%0d/%b want 00/ff/0/1", res_max, res_min, res_count, res_err); nerr++; end ncmp++;
    accept_result(); done_en = 1'b1;
  endtask

  task automatic test_done_vs_expiry;
    int n;
    mem[16'h30] = 32'h7F800102; dly_cfg = TIMEOUT - 1;
    send_cmd(16'h0030, 16'd1);
    wait_result(n);
    if ({res_max, res_min, res_count, res_err} !== {8'h80, 8'h01, 16'd1, 1'b0}) begin
      $display("FAIL tie_result: got %h/%h/%0d/%b want 80/01/1/0", res_max, res_min, res_count, res_err); nerr++; end ncmp++;
    accept_result(); dly_cfg = 0;
  endtask

  task automatic test_reset_mid;
    int n = 0, s0, c0, seen = 0;
    mem[16'h40] = 32'h10203040; done_en = 1'b0;
    send_cmd(16'h0040, 16'd2);
    while (!acc_start && n < 50) begin tick(); n++; end
    tick(); tick(); tick();
    s0 = res_cnt;
    arst = 1'b1; tick();
    if ({busy, cmd_ready, res_valid, acc_data_o} !== 35'h0) begin
      $display("FAIL mid_rst_outs: busy/ready/valid %b data %h want 0", {busy, cmd_ready, res_valid}, acc_data_o); nerr++; end ncmp++;
    arst = 1'b0; done_en = 1'b1; #1;
    if (cmd_ready !== 1'b1) begin $display("FAIL mid_rst_ready: got %b want 1", cmd_ready); nerr++; end ncmp++;
    for (int i = 0; i < 20; i++) begin tick(); if (res_valid) seen++; end
    if (seen !== 0) begin $display("FAIL mid_no_result: got %0d valid cycles want 0", seen); nerr++; end ncmp++;
    mem[16'h50] = 32'hFFFFFFFF; c0 = clr_cnt;
    send_cmd(16'h0050, 16'd1);
    wait_result(n);
    if (clr_cnt - c0 !== 1) begin $display("FAIL mid_clear: got %0d want 1", clr_cnt - c0); nerr++; end ncmp++;
    if ({res_max, res_min, res_count, res_err} !== {8'hFF, 8'hFF, 16'd1, 1'b0}) begin
      $display("FAIL mid_result: got %h/%h/%0d/%b want ff/ff/1/0", res_max, res_min, res_count, res_err); nerr++; end ncmp++;
    accept_result();
    if (res_cnt - s0 !== 1) begin $display("FAIL mid_nres: got %0d want 1", res_cnt - s0); nerr++; end ncmp++;
  endtask

  task automatic test_backpressure;
    int n;
    dly_cfg = 2;
    send_cmd(16'h0010, 16'd3);
    wait_result(n);
    for (int i = 0; i < 5; i++) begin
      if ({res_valid, cmd_ready, res_max, res_min, res_count, res_err} !== {1'b1, 1'b0, 8'h0C, 8'h01, 16'd3, 1'b0}) begin
        $display("FAIL bp_hold%0d: got v%b r%b %h/%h/%0d/%b want v1 r0 0c/01/3/0",
                 i, res_valid, cmd_ready, res_max, res_min, res_count, res_err); nerr++; end
      ncmp++;
      tick();
    end
    res_ready = 1'b1; #1;
    if (cmd_ready !== 1'b0) begin $display("FAIL bp_ready_same: got %b want 0", cmd_ready); nerr++; end ncmp++;
    tick(); res_ready = 1'b0;
    if ({cmd_ready, res_valid} !== 2'b10) begin
      $display("FAIL bp_ready_next: got ready/valid %b want 10", {cmd_ready, res_valid}); nerr++; end ncmp++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_wrap();
    test_timeout();
    test_done_vs_expiry();
    test_reset_mid();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule
